lsu_seq: RTL and testbench
==========================

# lsu_seq

Sequential, parametrised load/store unit for the pipeline's memory stage. It accepts one load/store request at a time from the execute stage and drives a handshaked data-memory port with byte-lane masks. Load data is returned aligned and sign/zero-extended. Accesses may be at any byte offset; when enabled, an access that crosses a data-word boundary is split into two memory beats.

## Interface
Parameters:
- DATA_W, 32: memory/data width in bits; legal values are 32 and 64. BYTES = DATA_W/8.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  lsu_pkg::size_e: B, H, W, D.
- req_unsigned  in  1  zero-extend load data (LBU/LHU/LWU).
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  DATA_W  store data, right-aligned.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  aligned address; low log2(BYTES) bits are 0.
- mem_mask  out  BYTES  byte-lane enables.
- mem_wdata  out  DATA_W  lane-positioned store data.
- mem_ack  in  1  memory has completed the beat; mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  read data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load result; 0 for stores and errors.
- rsp_err  out  1  access rejected; qualified by rsp_valid.
- busy  out  1  stall request to the pipeline, equal to !req_ready.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready = 1. When req_valid is high:
  - Capture the request and compute the byte offset off = addr mod BYTES and the access width n = 1, 2, 4 or 8 bytes.
  - Go to BEAT0, or to RESP with the error flag set if the request is illegal.
- Illegal requests:
  - size D when DATA_W = 32.
  - A crossing access (off + n > BYTES) when the split feature is compiled out.
  - No memory access is made for an illegal request.
- BEAT0: mem_req = 1, mem_addr = addr with low bits cleared, mem_mask = n ones shifted left by off (truncated to BYTES lanes), mem_wdata = wdata shifted left by 8·off.
  - On mem_ack, go to BEAT1 if crossing, else RESP.
- BEAT1: mem_addr = BEAT0 address + BYTES, mem_mask = low (off + n − BYTES) lanes, mem_wdata = wdata shifted right by 8·(BYTES − off).
  - On mem_ack, go to RESP.
- Load assembly: lanes from each beat are registered on its ack, concatenated, shifted right by 8·off, truncated to n bytes, then extended (signed unless req_unsigned).
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- All mem_* outputs are held stable while mem_req = 1 and mem_ack = 0. mem_req is 0 in IDLE and RESP.
- Stores never return data; rsp_rdata = 0.

## Timing
- Reset values: state IDLE, req_ready 1, busy 0, mem_req 0, mem_we 0, mem_addr 0, mem_mask 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- Latency: request accepted at cycle 0. mem_req rises at cycle 1. With ack on first cycle, rsp_valid occurs at cycle 2 for a single beat and cycle 3 for a split access.
- Illegal request: rsp_valid with rsp_err at cycle 1.
- Throughput: one request per (beats + 2) cycles best case. req_ready is low from the cycle after acceptance through RESP.
- mem_ack received outside BEAT0/BEAT1 is ignored.
- rst_n asserted mid-access: mem_req drops immediately (asynchronously), the in-flight beat is abandoned, and no response is issued.

## Configuration
- LSU_MISALIGNED_SPLIT_EN defined: crossing accesses are split into BEAT0 and BEAT1 as described above.
- LSU_MISALIGNED_SPLIT_EN undefined: crossing accesses complete with rsp_err = 1 and no memory access. The BEAT1 state and its data paths are not built.
- Non-crossing accesses at any offset are single-beat in both builds.

## Structure
- Package lsu_pkg contains:
  - size_e enum {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11}.
  - state_e enum.
  - Function size_bytes(size_e).
- Sub-module lsu_lane_align (combinational): mask generation, store-lane shift, and load shift plus extension. It is instantiated once and shared by both beats.

## Test plan
- LW at addr 0x100 with mem_rdata 0x8000_00F0, ack on first cycle -> rsp_valid at cycle 2, rsp_rdata 0x8000_00F0, mem_mask 4'b1111.
- LB at addr 0x103 with mem_rdata 0x80FF_0000 -> mem_mask 4'b1000, rsp_rdata 0xFFFF_FF80. The same access as LBU -> 0x0000_0080.
- SH of 0xBEEF at addr 0x101, DATA_W 32 -> mem_mask 4'b0110, mem_wdata 0x00BE_EF00, single beat.
- SW of 0x1122_3344 at addr 0x103, split enabled:
  - Beat 0: addr 0x100, mask 4'b1000, wdata 0x4400_0000.
  - Beat 1: addr 0x104, mask 4'b0111, wdata 0x0011_2233.
  - rsp_valid at cycle 3.
  - With split disabled -> rsp_err at cycle 1 and mem_req never asserted.
- LD with DATA_W 32 -> rsp_err. mem_ack delayed 3 cycles -> mem_* outputs stable throughout, rsp_valid on the cycle after ack.
- rst_n pulsed low during BEAT0 -> mem_req is 0 in the same cycle, no rsp_valid afterwards, req_ready 1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the sequential load/store unit.
// Split support for crossing accesses: LSU_MISALIGNED_SPLIT_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10,
        RESP  = 2'b11
    } state_e;

    function automatic logic [3:0] size_bytes(size_e s);
        return 4'd1 << s;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: masks, store shift, load shift and extension.
// One instance serves both memory beats via beat_i.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int BYTES = DATA_W / 8,
    localparam int OFF_W = $clog2(BYTES)
) (
    input  logic                beat_i,
    input  logic [OFF_W-1:0]    off_i,
    input  size_e               size_i,
    input  logic                uns_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [2*DATA_W-1:0] rdata_i,
    output logic [BYTES-1:0]    mask_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [3:0]          n;
    logic [2*BYTES-1:0]  mask_w;
    logic [2*DATA_W-1:0] data_w;
    logic [DATA_W-1:0]   rd_sh;
    logic                sgn;
    int                  nb;

    // Double-width views: low half feeds beat 0, high half beat 1.
    always_comb begin
        n       = size_bytes(size_i);
        nb      = 8 * int'(n);
        mask_w  = ((2*BYTES)'(1) << n) - (2*BYTES)'(1);
        mask_w  = mask_w << off_i;
        data_w  = {{DATA_W{1'b0}}, wdata_i} << {off_i, 3'b000};
        mask_o  = beat_i ? mask_w[2*BYTES-1:BYTES] : mask_w[BYTES-1:0];
        wdata_o = beat_i ? data_w[2*DATA_W-1:DATA_W]
                         : data_w[DATA_W-1:0];
        rd_sh   = DATA_W'(rdata_i >> {off_i, 3'b000});
        sgn     = 1'b0;
        unique case (size_i)
            SZ_B: sgn = rd_sh[7];
            SZ_H: sgn = rd_sh[15];
            SZ_W: sgn = rd_sh[31];
            SZ_D: sgn = rd_sh[DATA_W-1];
            default: sgn = 1'b0;
        endcase
        rdata_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rdata_o[i] = (i < nb) ? rd_sh[i] : (!uns_i && sgn);
        end
    end

endmodule

// File: rtl/lsu_seq.sv
// Sequential load/store unit for the memory stage.
// LSU_MISALIGNED_SPLIT_EN enables two-beat word-crossing accesses.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  size_e               req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    state_e              state_q, state_d;
    logic                we_q, uns_q, err_q;
    size_e               size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rd0_q;
    logic                req_cross, req_illegal, beat;
    logic [BYTES-1:0]    al_mask;
    logic [DATA_W-1:0]   al_wdata, al_rdata;
    logic [2*DATA_W-1:0] rd_cat;

    assign req_cross = (int'(req_addr[OFF_W-1:0])
                        + int'(size_bytes(req_size))) > BYTES;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              cross_q;
    logic [DATA_W-1:0] rd1_q;
    assign req_illegal = (req_size == SZ_D) && (DATA_W == 32);
    assign rd_cat      = {rd1_q, rd0_q};
`else
    assign req_illegal = ((req_size == SZ_D) && (DATA_W == 32))
                         || req_cross;
    assign rd_cat      = {{DATA_W{1'b0}}, rd0_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            cross_q <= 1'b0;
            rd1_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_illegal;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
                cross_q <= req_cross;
`endif
            end
            if (state_q == BEAT0 && mem_ack) rd0_q <= mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (state_q == BEAT1 && mem_ack) rd1_q <= mem_rdata;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        beat      = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_illegal ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_req = 1'b1;
`ifdef LSU_MISALIGNED_SPLIT_EN
                if (mem_ack) state_d = cross_q ? BEAT1 : RESP;
`else
                if (mem_ack) state_d = RESP;
`endif
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            BEAT1: begin
                mem_req = 1'b1;
                beat    = 1'b1;
                if (mem_ack) state_d = RESP;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .beat_i  (beat),
        .off_i   (addr_q[OFF_W-1:0]),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .rdata_i (rd_cat),
        .mask_o  (al_mask),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata)
    );

    // All memory outputs park at zero outside the beat states.
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req
        ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
          + (beat ? ADDR_W'(BYTES) : ADDR_W'(0))
        : '0;
    assign mem_mask  = mem_req ? al_mask : '0;
    assign mem_wdata = mem_req ? al_wdata : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? al_rdata : '0;
    assign busy      = !req_ready;

endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: vector table, corner sequences
// and randomized requests against a byte-level memory model.
module tb_lsu_seq;
    import lsu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk, rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    size_e         req_size;
    logic [AW-1:0] req_addr, mem_addr;
    logic [DW-1:0] req_wdata, mem_wdata, mem_rdata, rsp_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [3:0]    mem_mask;
    logic          rsp_valid, rsp_err, busy;

    lsu_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_mask(mem_mask), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] mem [0:1023];

    int          obs_beats, obs_lat, obs_unstable, obs_rdy_bad;
    logic        obs_err;
    logic [31:0] obs_rdata;
    logic [31:0] obs_addr [4];
    logic [3:0]  obs_mask [4];
    logic [31:0] obs_wd [4];
    logic        obs_we [4];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] preset;
        int          dly;
        logic        err;
        int          lat;
        int          beats;
        logic [3:0]  mask0;
        logic [31:0] wd0;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [9:0] i;
        i = a[9:0];
        return {mem[i+10'd3], mem[i+10'd2], mem[i+10'd1], mem[i]};
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        logic [9:0] i;
        i = {a[9:2], 2'b00};
        for (int k = 0; k < 4; k++) mem[i+10'(k)] = w[8*k +: 8];
    endtask

    // Drives one request and plays memory; records what the DUT did.
    task automatic run(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, input int dly);
        int   wc;
        int   idx;
        logic in_beat;
        logic [9:0] mi;
        obs_beats = 0; obs_lat = -1; obs_unstable = 0;
        obs_rdy_bad = 0; obs_err = 1'bx; obs_rdata = 'x;
        wc = 0; idx = 0; in_beat = 1'b0;
        if (!req_ready) obs_rdy_bad++;
        req_valid = 1'b1; req_we = we; req_size = size_e'(sz);
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 30 && obs_lat < 0; c++) begin
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (req_ready || busy != !req_ready) obs_rdy_bad++;
            if (rsp_valid) begin
                obs_lat = c; obs_err = rsp_err; obs_rdata = rsp_rdata;
            end
            if (mem_req) begin
                if (!in_beat) begin
                    idx = (obs_beats < 3) ? obs_beats : 3;
                    obs_addr[idx] = mem_addr; obs_mask[idx] = mem_mask;
                    obs_wd[idx] = mem_wdata; obs_we[idx] = mem_we;
                    in_beat = 1'b1; wc = 0;
                end else if (mem_addr !== obs_addr[idx] ||
                             mem_mask !== obs_mask[idx] ||
                             mem_wdata !== obs_wd[idx] ||
                             mem_we !== obs_we[idx]) begin
                    obs_unstable++;
                end
                if (wc == dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd_word(mem_addr);
                    mi = mem_addr[9:0];
                    for (int l = 0; l < 4; l++)
                        if (mem_we && mem_mask[l])
                            mem[mi+10'(l)] = mem_wdata[8*l +: 8];
                    obs_beats++;
                    in_beat = 1'b0;
                end
                wc++;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        int          n, off, beats, lat, a, bt;
        logic        we, uns, err;
        logic [1:0]  sz;
        logic [31:0] addr, wd;
        logic [63:0] v;
        logic [3:0]  em [2];
        logic [31:0] ew [2];
        logic [31:0] bm;
        int          dly, cnt;

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = SZ_B; req_unsigned = 1'b0; req_addr = '0;
        req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_memout", {mem_we, mem_addr, mem_mask, mem_wdata}, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray acks while idle must be ignored.
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            @(posedge clk); #1;
            if (mem_req || rsp_valid || !req_ready) cnt++;
        end
        mem_ack = 1'b0;
        chk("stray_ack", cnt, 0);

        tbl[0] = '{0, 2, 0, 'h100, 0, 'h800000F0, 0,
                   0, 2, 1, 4'hF, 0, 'h800000F0};
        tbl[1] = '{0, 0, 0, 'h103, 0, 'h80FF0000, 0,
                   0, 2, 1, 4'h8, 0, 'hFFFFFF80};
        tbl[2] = '{0, 0, 1, 'h103, 0, 'h80FF0000, 0,
                   0, 2, 1, 4'h8, 0, 'h00000080};
        tbl[3] = '{1, 1, 0, 'h101, 'hBEEF, 0, 0,
                   0, 2, 1, 4'h6, 'h00BEEF00, 0};
`ifdef LSU_MISALIGNED_SPLIT_EN
        tbl[4] = '{1, 2, 0, 'h103, 'h11223344, 0, 0,
                   0, 3, 2, 4'h8, 'h44000000, 0};
`else
        tbl[4] = '{1, 2, 0, 'h103, 'h11223344, 0, 0,
                   1, 1, 0, 4'h0, 0, 0};
`endif
        tbl[5] = '{0, 3, 0, 'h200, 0, 0, 0,
                   1, 1, 0, 4'h0, 0, 0};
        tbl[6] = '{0, 2, 0, 'h100, 0, 'h12345678, 3,
                   0, 5, 1, 4'hF, 0, 'h12345678};
        tbl[7] = '{0, 1, 0, 'h102, 0, 'h80010000, 0,
                   0, 2, 1, 4'hC, 0, 'hFFFF8001};
        tbl[8] = '{0, 1, 1, 'h106, 0, 'hF00D0000, 1,
                   0, 3, 1, 4'hC, 0, 'h0000F00D};
        tbl[9] = '{1, 0, 0, 'h202, 'hA5, 0, 2,
                   0, 4, 1, 4'h4, 'h00A50000, 0};

        for (int t = 0; t < 10; t++) begin
            if (!tbl[t].we) put_word(tbl[t].addr, tbl[t].preset);
            run(tbl[t].we, tbl[t].sz, tbl[t].uns, tbl[t].addr,
                tbl[t].wd, tbl[t].dly);
            chk($sformatf("v%0d_err", t), obs_err, tbl[t].err);
            chk($sformatf("v%0d_lat", t), obs_lat, tbl[t].lat);
            chk($sformatf("v%0d_beats", t), obs_beats, tbl[t].beats);
            chk($sformatf("v%0d_rdata", t), obs_rdata, tbl[t].rdata);
            chk($sformatf("v%0d_stable", t), obs_unstable, 0);
            chk($sformatf("v%0d_ready", t), obs_rdy_bad, 0);
            if (obs_beats > 0) begin
                chk($sformatf("v%0d_addr0", t), obs_addr[0],
                    tbl[t].addr & ~32'h3);
                chk($sformatf("v%0d_mask0", t), obs_mask[0],
                    tbl[t].mask0);
                chk($sformatf("v%0d_wd0", t), obs_wd[0], tbl[t].wd0);
            end
        end

`ifdef LSU_MISALIGNED_SPLIT_EN
        run(1, 2, 0, 'h103, 'h11223344, 0);
        chk("sw_split_b0addr", obs_addr[0], 'h100);
        chk("sw_split_b1addr", obs_addr[1], 'h104);
        chk("sw_split_b1mask", obs_mask[1], 4'h7);
        chk("sw_split_b1wd", obs_wd[1], 'h00112233);
        chk("sw_split_lat", obs_lat, 3);
`endif

        // Reset asserted while beat 0 is waiting for its ack.
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W;
        req_unsigned = 1'b0; req_addr = 'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid_req_before", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_req_drop", mem_req, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || !req_ready || mem_req) cnt++;
            @(posedge clk); #1;
        end
        chk("rstmid_quiet", cnt, 0);

        for (int r = 0; r < 300; r++) begin
            we   = 1'($urandom);
            uns  = 1'($urandom);
            sz   = ($urandom_range(0, 9) == 0) ? 2'd3
                                               : 2'($urandom_range(0, 2));
            addr = $urandom_range(0, 'h3F0);
            wd   = $urandom;
            dly  = $urandom_range(0, 2);
            n    = 1 << sz;
            off  = addr % 4;
            err  = (sz == 2'd3) || ((off + n > 4) && !SPLIT);
            beats = err ? 0 : ((off + n > 4) ? 2 : 1);
            lat  = err ? 1 : 1 + beats * (dly + 1);
            em[0] = 0; em[1] = 0; ew[0] = 0; ew[1] = 0; v = 0;
            for (int k = 0; k < n && !err; k++) begin
                a  = int'(addr) + k;
                bt = (a / 4 != int'(addr) / 4) ? 1 : 0;
                em[bt][a % 4] = 1'b1;
                ew[bt][8*(a % 4) +: 8] = wd[8*k +: 8];
                v[8*k +: 8] = mem[a];
            end
            if (!uns && v[8*n-1]) v = v | (~64'h0 << (8*n));
            if (we || err) v = 0;
            run(we, sz, uns, addr, wd, dly);
            chk($sformatf("r%0d_err", r), obs_err, err);
            chk($sformatf("r%0d_lat", r), obs_lat, lat);
            chk($sformatf("r%0d_beats", r), obs_beats, beats);
            chk($sformatf("r%0d_rdata", r), obs_rdata, v[31:0]);
            chk($sformatf("r%0d_stable", r), obs_unstable + obs_rdy_bad, 0);
            for (int b = 0; b < beats && b < obs_beats; b++) begin
                for (int l = 0; l < 4; l++)
                    bm[8*l +: 8] = {8{obs_mask[b][l]}};
                chk($sformatf("r%0d_b%0d_addr", r, b), obs_addr[b],
                    (addr & ~32'h3) + 32'(4 * b));
                chk($sformatf("r%0d_b%0d_mask", r, b), obs_mask[b], em[b]);
                chk($sformatf("r%0d_b%0d_wd", r, b),
                    we ? (obs_wd[b] & bm) : 32'h0, we ? ew[b] : 32'h0);
                chk($sformatf("r%0d_b%0d_we", r, b), obs_we[b], we);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
